// File: rtl/hardware_pair_pkg.sv
// Shared definitions for the packed Maybe-pair encoder/decoder pair:
// tag constants, widths, field layouts and the unpack FSM states.
package hardware_pair_pkg;

    localparam int unsigned PAYLOAD_W = 63;
    localparam int unsigned WORD_W    = 65;
    localparam int unsigned PAIR_W    = 129;

    localparam logic [1:0] PAIR_EMPTY = 2'b00;
    localparam logic [1:0] PAIR_ONE   = 2'b01;
    localparam logic [1:0] PAIR_TWO   = 2'b10;
    localparam logic [1:0] PAIR_BAD   = 2'b11;

    localparam logic [1:0] WORD_VAL = 2'b10;
    localparam logic [1:0] WORD_END = 2'b00;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        W1   = 2'd1,
        W2   = 2'd2,
        END  = 2'd3
    } pair_state_t;

    typedef struct packed {
        logic                 just;
        logic [1:0]           tag;
        logic [PAYLOAD_W-1:0] v1;
        logic [PAYLOAD_W-1:0] v2;
    } pair_t;

    // Held copy of an accepted pair; the Just flag is not needed once accepted.
    typedef struct packed {
        logic [1:0]           tag;
        logic [PAYLOAD_W-1:0] v1;
        logic [PAYLOAD_W-1:0] v2;
    } pair_hold_t;

    function automatic logic [WORD_W-1:0] make_word(input logic [1:0] tag,
                                                    input logic [PAYLOAD_W-1:0] payload);
        return {tag, payload};
    endfunction

endpackage

// File: rtl/hardware_pair_unpack_if.sv
// Input pair stream and output word stream of the pair unpacker.
interface hardware_pair_unpack_if;
    import hardware_pair_pkg::*;

    logic [PAIR_W-1:0] in_i;
    logic              in_valid_i;
    logic              in_ready_o;
    logic [WORD_W-1:0] out_o;
    logic              out_valid_o;
    logic              out_ready_i;
    logic              out_last_o;

    modport master (
        output in_i, in_valid_i, out_ready_i,
        input  in_ready_o, out_o, out_valid_o, out_last_o
    );

    modport slave (
        input  in_i, in_valid_i, out_ready_i,
        output in_ready_o, out_o, out_valid_o, out_last_o
    );
endinterface

// File: rtl/hardware_sat_counter.sv
// Saturating up-counter with synchronous reset and clear.
module hardware_sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_inc,
    input  logic             i_clear,
    output logic [CNT_W-1:0] o_cnt
);
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;
endmodule

// File: rtl/hardware_pair_unpack.sv
// Re-serialises a 129-bit Maybe(tag, v1, v2) pair into tagged 65-bit words
// ending with an end word; Nothing inputs are counted, tag-11 inputs flag err_o.
module hardware_pair_unpack
    import hardware_pair_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic                 system1000,
    input  logic                 system1000_rst,
    hardware_pair_unpack_if.slave bus,
    output logic [CNT_W-1:0]     drop_cnt_o,
    output logic                 err_o
);
    pair_state_t       r_state;
    pair_hold_t        r_hold;
    logic              r_in_ready;
    logic              r_out_valid;
    logic              r_out_last;
    logic              r_err;

    pair_t             w_in;
    logic              w_accept;
    logic              w_out_fire;
    logic              w_drop;
    logic [WORD_W-1:0] w_out;

    assign w_in       = bus.in_i;
    assign w_accept   = bus.in_valid_i & r_in_ready;
    assign w_out_fire = r_out_valid & bus.out_ready_i;
    assign w_drop     = w_accept & ~w_in.just;

    always_ff @(posedge system1000) begin
        if (system1000_rst) begin
            r_state     <= IDLE;
            r_hold      <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_hold <= '{tag: w_in.tag, v1: w_in.v1, v2: w_in.v2};
                        if (w_in.just) begin
                            case (w_in.tag)
                                PAIR_EMPTY: begin
                                    r_state     <= END;
                                    r_in_ready  <= 1'b0;
                                    r_out_valid <= 1'b1;
                                    r_out_last  <= 1'b1;
                                end
                                PAIR_ONE, PAIR_TWO: begin
                                    r_state     <= W1;
                                    r_in_ready  <= 1'b0;
                                    r_out_valid <= 1'b1;
                                end
                                default: r_err <= 1'b1;
                            endcase
                        end
                    end
                end
                W1: begin
                    if (w_out_fire) begin
                        if (r_hold.tag == PAIR_TWO) begin
                            r_state <= W2;
                        end else begin
                            r_state    <= END;
                            r_out_last <= 1'b1;
                        end
                    end
                end
                W2: begin
                    if (w_out_fire) begin
                        r_state    <= END;
                        r_out_last <= 1'b1;
                    end
                end
                END: begin
                    if (w_out_fire) begin
                        r_state     <= IDLE;
                        r_in_ready  <= 1'b1;
                        r_out_valid <= 1'b0;
                        r_out_last  <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_out_last  <= 1'b0;
                end
            endcase
        end
    end

    // Word data is selected from the held pair, so it cannot move under backpressure.
    always_comb begin
        w_out = '0;
        case (r_state)
            W1:      w_out = make_word(WORD_VAL, r_hold.v1);
            W2:      w_out = make_word(WORD_VAL, r_hold.v2);
            END:     w_out = make_word(WORD_END, '0);
            default: w_out = '0;
        endcase
    end

    hardware_sat_counter #(
        .CNT_W(CNT_W)
    ) u_drop_cnt (
        .i_clk   (system1000),
        .i_rst   (system1000_rst),
        .i_inc   (w_drop),
        .i_clear (1'b0),
        .o_cnt   (drop_cnt_o)
    );

    assign bus.in_ready_o  = r_in_ready;
    assign bus.out_o       = w_out;
    assign bus.out_valid_o = r_out_valid;
    assign bus.out_last_o  = r_out_last;
    assign err_o           = r_err;
endmodule
